line_fill_responder: RTL and testbench

LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

---
 rtl/line_fill_responder.sv | 102 ++++++++++
 tb/tb_line_fill_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_responder.sv
// Instruction-cache line fill engine: on a miss it streams WORDS sequential reads
// from instruction memory and assembles them into one cache line.
module line_fill_responder #(
  parameter int WORDS = 8,
  parameter int OFF_W = 5
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   fill_req,
  input  logic [31:0]            fill_addr,
  output logic                   mem_rden,
  output logic [31:0]            mem_addr,
  input  logic [31:0]            mem_rdata,
  output logic [32*WORDS-1:0]    line_data,
  output logic [31-OFF_W:0]      line_tag,
  output logic                   fill_done,
  output logic                   busy
);

  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [31:0]      base;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] cap_cnt;
  logic [CNT_W-1:0] issue_nxt;
  logic             cap_vld;

  assign issue_nxt = issue_cnt + CNT_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      cap_vld   <= 1'b0;
      mem_rden  <= 1'b0;
      mem_addr  <= '0;
      line_data <= '0;
      line_tag  <= '0;
      fill_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Read data trails mem_rden by one cycle; the delayed enable marks it valid.
      cap_vld <= mem_rden;
      if (cap_vld) begin
        line_data[32*cap_cnt[IDX_W-1:0] +: 32] <= mem_rdata;
        cap_cnt <= cap_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (fill_req) begin
            base      <= {fill_addr[31:OFF_W], {OFF_W{1'b0}}};
            line_tag  <= fill_addr[31:OFF_W];
            mem_addr  <= {fill_addr[31:OFF_W], {OFF_W{1'b0}}};
            mem_rden  <= 1'b1;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_cnt == LAST) begin
            mem_rden <= 1'b0;
            mem_addr <= '0;
            state    <= DRAIN;
          end else begin
            // base is line-aligned, so adding the word offset never carries out of the line
            issue_cnt <= issue_nxt;
            mem_addr  <= base + 32'({issue_nxt, 2'b00});
          end
        end
        DRAIN: begin
          if (cap_vld && cap_cnt == LAST) begin
            fill_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          fill_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_rden  <= 1'b0;
          mem_addr  <= '0;
          fill_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Bench for line_fill_responder: three instances (WORDS = 8, 2, 16), each with a
// word-equals-address memory and a scoreboard of expected reads and completed lines.
module tb_line_fill_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [31:0] faddr [3];
  logic [2:0]  rden;
  logic [2:0]  done;
  logic [2:0]  busy;
  logic [31:0] maddr [3];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int W  = (g == 0) ? 8 : (g == 1) ? 2 : 16;
    localparam int OW = $clog2(W) + 2;

    logic [32*W-1:0] ldata;
    logic [31-OW:0]  ltag;
    logic [31:0]     mrdata;

    logic [31:0]  aq [$];
    int           acq [$];
    logic [511:0] lq [$];
    logic [31:0]  tq [$];
    int           dq [$];
    int           m_cnt = 0;

    function automatic logic [31:0] base_of(input logic [31:0] a);
      return a & ~((32'd1 << OW) - 32'd1);
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] b);
      logic [511:0] r;
      r = '0;
      for (int i = 0; i < W; i++) r[32*i +: 32] = b + 32'(4 * i);
      return r;
    endfunction

    line_fill_responder #(.WORDS(W), .OFF_W(OW)) dut (
      .CLK(clk), .RST(rst), .fill_req(req[g]), .fill_addr(faddr[g]),
      .mem_rden(rden[g]), .mem_addr(maddr[g]), .mem_rdata(mrdata),
      .line_data(ldata), .line_tag(ltag), .fill_done(done[g]), .busy(busy[g])
    );

    always @(posedge clk) mrdata <= maddr[g];

    // Reference: an accepted request owns the engine for W+2 cycles.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_cnt <= 0;
        aq.delete(); acq.delete(); lq.delete(); tq.delete(); dq.delete();
      end else if (m_cnt == 0) begin
        if (req[g]) begin
          for (int k = 0; k < W; k++) begin
            aq.push_back(base_of(faddr[g]) + 32'(4 * k));
            acq.push_back(cyc + 1 + k);
          end
          lq.push_back(line_of(base_of(faddr[g])));
          tq.push_back(faddr[g] >> OW);
          dq.push_back(cyc + W + 2);
          m_cnt <= W + 2;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        if (rden[g]) begin
          if (aq.size() == 0) chk($sformatf("rden_extra%0d", g), 512'(1), 512'(0));
          else begin
            chk($sformatf("mem_addr%0d", g), 512'(maddr[g]), 512'(aq.pop_front()));
            chk($sformatf("rden_cyc%0d", g), 512'(cyc), 512'(acq.pop_front()));
          end
        end else begin
          chk($sformatf("addr_idle%0d", g), 512'(maddr[g]), 512'(0));
        end
        chk($sformatf("busy%0d", g), 512'(busy[g]), 512'(m_cnt != 0));
        if (done[g]) begin
          if (lq.size() == 0) chk($sformatf("done_extra%0d", g), 512'(1), 512'(0));
          else begin
            chk($sformatf("line%0d", g), 512'(ldata), lq.pop_front());
            chk($sformatf("tag%0d", g), 512'(ltag), 512'(tq.pop_front()));
            chk($sformatf("done_cyc%0d", g), 512'(cyc), 512'(dq.pop_front()));
            chk($sformatf("reads_left%0d", g), 512'(aq.size()), 512'(0));
          end
        end else if (dq.size() > 0 && cyc > dq[0]) begin
          chk($sformatf("done_missing%0d", g), 512'(0), 512'(1));
          void'(lq.pop_front()); void'(tq.pop_front()); void'(dq.pop_front());
        end
      end
    end
  end

  task automatic wait_done(input int g, input int limit);
    int n;
    n = 0;
    while (!done[g] && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done[g]) chk("done_timeout", 512'(0), 512'(1));
  endtask

  task automatic pulse(input int g, input logic [31:0] a);
    req[g]   = 1'b1;
    faddr[g] = a;
    @(negedge clk);
    req[g]   = 1'b0;
  endtask

  initial begin
    logic [511:0] e;
    int n;
    for (int g = 0; g < 3; g++) faddr[g] = '0;
    repeat (3) @(negedge clk);
    chk("rst_rden", 512'(rden[0]), 512'(0));
    chk("rst_addr", 512'(maddr[0]), 512'(0));
    chk("rst_done", 512'(done[0]), 512'(0));
    chk("rst_busy", 512'(busy[0]), 512'(0));
    chk("rst_line", 512'(inst[0].ldata), 512'(0));
    chk("rst_tag", 512'(inst[0].ltag), 512'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic fill from the middle of a line
    pulse(0, 32'h0000_0134);
    wait_done(0, 40);
    repeat (3) @(negedge clk);
    e = '0;
    for (int i = 0; i < 8; i++) e[32*i +: 32] = 32'h120 + 32'(4 * i);
    chk("line_hold", 512'(inst[0].ldata), e);
    chk("tag_hold", 512'(inst[0].ltag), 512'(32'h9));

    // Request held high for the whole fill
    req[0] = 1'b1;
    faddr[0] = 32'h0000_0400;
    wait_done(0, 40);
    req[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back: new request in the cycle after fill_done
    pulse(0, 32'h0000_00AC);
    wait_done(0, 40);
    req[0] = 1'b1;
    faddr[0] = 32'h0000_0200;
    repeat (2) @(negedge clk);
    req[0] = 1'b0;
    wait_done(0, 40);
    repeat (2) @(negedge clk);

    // Requests during ISSUE must be ignored
    pulse(0, 32'h0000_0300);
    faddr[0] = 32'h0000_07E0;
    for (int i = 0; i < 4; i++) begin
      req[0] = ~req[0];
      @(negedge clk);
    end
    req[0] = 1'b0;
    wait_done(0, 40);
    repeat (2) @(negedge clk);

    // Reset during issue k=4
    pulse(0, 32'h0000_0540);
    n = 0;
    while (!(rden[0] && maddr[0] == 32'h550) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("k4_seen", 512'(maddr[0]), 512'(32'h550));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rden", 512'(rden[0]), 512'(0));
    chk("mid_rst_busy", 512'(busy[0]), 512'(0));
    chk("mid_rst_addr", 512'(maddr[0]), 512'(0));
    chk("mid_rst_line", 512'(inst[0].ldata), 512'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done[0]) n++;
    end
    chk("no_done_after_rst", 512'(n), 512'(0));
    pulse(0, 32'h0000_0180);
    wait_done(0, 40);
    repeat (2) @(negedge clk);

    // Parameter sweep: WORDS=2 and WORDS=16 together
    req[1] = 1'b1; faddr[1] = 32'h0000_0134;
    req[2] = 1'b1; faddr[2] = 32'h0000_05C4;
    @(negedge clk);
    req[1] = 1'b0;
    req[2] = 1'b0;
    wait_done(2, 40);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
